i2c_line_filter: RTL
====================

# i2c_line_filter

Digital glitch filter and bus-condition detector for the I2C peripheral. It consumes the SCL and SDA levels produced by the two-flop input synchronizers. It outputs debounced line levels, single-cycle SCL edge strobes, START/STOP/repeated-START strobes and a bus-busy flag. The I2C host/target FSMs use these outputs instead of raw pad levels.

## Interface
- `FilterCycles`, default 4: consecutive stable samples needed before a filtered line changes. Legal range 1..255.
- `TimeoutCycles`, default 1024: cycles SCL may stay low while the bus is busy before the stuck flag is raised. Legal range 2..2^20.
- `clk_i`  in  1  peripheral clock; the single clock of the block.
- `rst_i`  in  1  asynchronous, active-high reset.
- `scl_sync_i`  in  1  SCL level, already double-synchronized to `clk_i`.
- `sda_sync_i`  in  1  SDA level, already double-synchronized to `clk_i`.
- `filt_en_i`  in  1  1: glitch filter active. 0: bypass, with 1-cycle register only.
- `scl_o`  out  1  filtered SCL level.
- `sda_o`  out  1  filtered SDA level.
- `scl_rise_o`  out  1  one-cycle strobe on a filtered SCL 0→1 change.
- `scl_fall_o`  out  1  one-cycle strobe on a filtered SCL 1→0 change.
- `start_o`  out  1  one-cycle strobe on a START or repeated START.
- `rstart_o`  out  1  one-cycle strobe on a repeated START only; always coincident with `start_o`.
- `stop_o`  out  1  one-cycle strobe on a STOP.
- `bus_busy_o`  out  1  high between a START and the next STOP.
- `scl_stuck_o`  out  1  SCL-low timeout flag. Tied 0 unless the timeout feature is compiled in.

## Operation
- Reset values:
  - `scl_o` = 1 and `sda_o` = 1 (idle bus).
  - All strobes = 0.
  - `bus_busy_o` = 0 and `scl_stuck_o` = 0.
  - Filter counters = 0, FSM state = BUS_IDLE, timeout counter = 0.
- Per-line filter, evaluated at each clock edge with `filt_en_i` = 1:
  - If raw equals filtered, the counter clears to 0.
  - Otherwise, if the counter equals `FilterCycles`-1, the filtered value takes the raw value and the counter clears.
  - Otherwise the counter increments.
  - Any pulse shorter than `FilterCycles` samples is therefore rejected completely.
- With `filt_en_i` = 0: filtered <= raw on every edge and the counters are held at 0. Toggling `filt_en_i` mid-pulse takes effect at the next edge; the partial count is discarded.
- SCL edge strobes are registered. Each strobe is high in exactly the cycle in which `scl_o` first shows the new level.
- Bus conditions are evaluated at the edge where `sda_o` changes:
  - SDA 1→0 with SCL filtered high before and after that edge is a START.
  - SDA 0→1 under the same SCL condition is a STOP.
  - If SCL and SDA change at the same edge, no START or STOP is reported.
- FSM with states BUS_IDLE and BUS_BUSY:
  - BUS_IDLE → BUS_BUSY on START: `start_o` pulses.
  - START in BUS_BUSY: `start_o` and `rstart_o` both pulse; the state stays BUS_BUSY.
  - BUS_BUSY → BUS_IDLE on STOP: `stop_o` pulses.
  - STOP in BUS_IDLE: `stop_o` pulses; the state stays BUS_IDLE.
  - `bus_busy_o` = (state == BUS_BUSY), registered.
- Reset asserted mid-transfer returns every output to its reset value immediately, because reset is asynchronous. The first START after reset is never flagged as repeated.

## Timing
- Filter path: a raw change first sampled at edge k, and held stable, appears on `scl_o`/`sda_o` after edge k+`FilterCycles`-1.
  - End-to-end latency from the pad is 2 synchronizer cycles plus `FilterCycles` cycles.
- Bypass path: 1 cycle.
- Strobes and `bus_busy_o` update at the same edge as the filtered level that causes them. There is no extra pipeline stage.
- No handshakes. Strobes are never stretched and never repeat for a stable level.

## Configuration
- Macro: `I2C_LINE_FILTER_TIMEOUT_EN`.
- Defined:
  - In BUS_BUSY, a counter increments on each cycle with `scl_o` = 0, saturating at `TimeoutCycles`.
  - When the counter reaches `TimeoutCycles`, `scl_stuck_o` is set.
  - The counter and the flag clear when `scl_o` = 1 or when the FSM enters BUS_IDLE.
  - The FSM state is not changed by the timeout.
- Not defined: no counter logic is present and `scl_stuck_o` is constant 0.

## Structure
- Package `i2c_line_pkg` contains:
  - Enum `bus_state_e` {BUS_IDLE, BUS_BUSY}.
  - Default constants `FILTER_CYCLES_DEFAULT` = 4 and `TIMEOUT_CYCLES_DEFAULT` = 1024.
- Sub-module `i2c_glitch_filter`: single-line counter filter with ports clock, reset, enable, raw, filtered, rise, fall. Instantiated twice, once for SCL and once for SDA.
- The top level contains the START/STOP decode, the FSM and the optional timeout counter.

## Test plan
- Glitch rejection:
  - `FilterCycles`=4, SCL low pulse of 3 cycles → `scl_o` stays 1 and no `scl_fall_o`.
  - Low pulse of 4 cycles → `scl_o` falls 3 cycles after the first low sample and `scl_fall_o` pulses once.
- START/STOP:
  - SCL high, SDA 1→0 → `start_o`=1 for one cycle, `bus_busy_o`=1, `rstart_o`=0.
  - Then SDA 0→1 with SCL high → `stop_o` pulses and `bus_busy_o`=0.
- Repeated START: while BUS_BUSY, drive SCL low, set SDA high, raise SCL, drop SDA → `start_o` and `rstart_o` pulse together; `bus_busy_o` stays 1.
- Simultaneous change: drive `scl_sync_i` and `sda_sync_i` so that both filtered lines flip at the same edge → no `start_o` or `stop_o`.
- Bypass and reset:
  - `filt_en_i`=0, 1-cycle SDA glitch → `sda_o` follows it with 1-cycle latency.
  - Assert `rst_i` while BUS_BUSY → `bus_busy_o`=0 and `scl_o`=`sda_o`=1 immediately.
- Timeout (macro defined), `TimeoutCycles`=16:
  - After START, hold SCL low → `scl_stuck_o`=1 once `scl_o` has been low for 16 cycles.
  - Release SCL → `scl_stuck_o` clears.

Source files
------------

// File: rtl/i2c_line_filter_pkg.sv
// i2c_line_filter: shared types and default constants.
// Optional feature macro: I2C_LINE_FILTER_TIMEOUT_EN (see top level).
package i2c_line_pkg;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_BUSY = 1'b1
  } bus_state_e;

  localparam int unsigned FILTER_CYCLES_DEFAULT  = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

  // Bits needed to hold the values 0..v.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/i2c_line_filter_if.sv
// i2c_line_filter: line inputs and filtered/strobe outputs.
// slave = filter block, master = consumer/driver side.
interface i2c_line_filter_if;

  logic scl_sync_i;
  logic sda_sync_i;
  logic filt_en_i;
  logic scl_o;
  logic sda_o;
  logic scl_rise_o;
  logic scl_fall_o;
  logic start_o;
  logic rstart_o;
  logic stop_o;
  logic bus_busy_o;
  logic scl_stuck_o;

  modport master (
    output scl_sync_i,
    output sda_sync_i,
    output filt_en_i,
    input  scl_o,
    input  sda_o,
    input  scl_rise_o,
    input  scl_fall_o,
    input  start_o,
    input  rstart_o,
    input  stop_o,
    input  bus_busy_o,
    input  scl_stuck_o
  );

  modport slave (
    input  scl_sync_i,
    input  sda_sync_i,
    input  filt_en_i,
    output scl_o,
    output sda_o,
    output scl_rise_o,
    output scl_fall_o,
    output start_o,
    output rstart_o,
    output stop_o,
    output bus_busy_o,
    output scl_stuck_o
  );

endinterface

// File: rtl/i2c_line_filter_glitch.sv
// i2c_glitch_filter: single-line counter filter with edge strobes.
// nxt_o exposes the level the filter takes at the coming edge.
module i2c_glitch_filter
  import i2c_line_pkg::*;
#(
  parameter int unsigned FilterCycles = FILTER_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic raw_i,
  output logic filt_o,
  output logic nxt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] LAST = 8'(FilterCycles - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       filt_q;
  logic       filt_d;

  // Next filtered level and stability count.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (!en_i) begin
      filt_d = raw_i;
    end else if (raw_i == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      filt_d = raw_i;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Filtered level plus strobes aligned with the level change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_o <= filt_d & ~filt_q;
      fall_o <= ~filt_d & filt_q;
    end
  end

  assign filt_o = filt_q;
  assign nxt_o  = filt_d;

endmodule

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: SCL/SDA glitch filter, START/STOP decode, busy FSM.
// Define I2C_LINE_FILTER_TIMEOUT_EN to build the SCL-low stuck timer.
module i2c_line_filter
  import i2c_line_pkg::*;
#(
  parameter int unsigned FilterCycles  = FILTER_CYCLES_DEFAULT,
  parameter int unsigned TimeoutCycles = TIMEOUT_CYCLES_DEFAULT
) (
  input logic             clk_i,
  input logic             rst_i,
  i2c_line_filter_if.slave bus
);

  logic scl_q;
  logic scl_n;
  logic sda_q;
  logic sda_n;
  logic start_c;
  logic stop_c;

  bus_state_e state_q;
  bus_state_e state_d;

  logic start_q;
  logic rstart_q;
  logic stop_q;
  logic busy_q;

  i2c_glitch_filter #(
    .FilterCycles(FilterCycles)
  ) u_scl (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (bus.filt_en_i),
    .raw_i (bus.scl_sync_i),
    .filt_o(scl_q),
    .nxt_o (scl_n),
    .rise_o(bus.scl_rise_o),
    .fall_o(bus.scl_fall_o)
  );

  i2c_glitch_filter #(
    .FilterCycles(FilterCycles)
  ) u_sda (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (bus.filt_en_i),
    .raw_i (bus.sda_sync_i),
    .filt_o(sda_q),
    .nxt_o (sda_n),
    .rise_o(),
    .fall_o()
  );

  // SCL must be high on both sides of the SDA edge; this also
  // rejects SCL and SDA flipping at the same edge.
  assign start_c = sda_q & ~sda_n & scl_q & scl_n;
  assign stop_c  = ~sda_q & sda_n & scl_q & scl_n;

  // Next bus state.
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      start_c: state_d = BUS_BUSY;
      stop_c:  state_d = BUS_IDLE;
      default: state_d = state_q;
    endcase
  end

  // Bus FSM with registered condition strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= BUS_IDLE;
      start_q  <= 1'b0;
      rstart_q <= 1'b0;
      stop_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_c;
      rstart_q <= start_c & (state_q == BUS_BUSY);
      stop_q   <= stop_c;
      busy_q   <= (state_d == BUS_BUSY);
    end
  end

`ifdef I2C_LINE_FILTER_TIMEOUT_EN
  localparam int unsigned TW = cnt_width(TimeoutCycles);
  localparam logic [TW-1:0] TMAX = TW'(TimeoutCycles);

  logic [TW-1:0] to_cnt_q;
  logic          stuck_q;

  // Count busy cycles with SCL low; clear when SCL returns or bus idles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
      stuck_q  <= 1'b0;
    end else if (scl_n || (state_d != BUS_BUSY)) begin
      to_cnt_q <= '0;
      stuck_q  <= 1'b0;
    end else if (!scl_q && (to_cnt_q != TMAX)) begin
      to_cnt_q <= to_cnt_q + 1'b1;
      stuck_q  <= (to_cnt_q + 1'b1) == TMAX;
    end
  end

  assign bus.scl_stuck_o = stuck_q;
`else
  assign bus.scl_stuck_o = 1'b0;
`endif

  assign bus.scl_o      = scl_q;
  assign bus.sda_o      = sda_q;
  assign bus.start_o    = start_q;
  assign bus.rstart_o   = rstart_q;
  assign bus.stop_o     = stop_q;
  assign bus.bus_busy_o = busy_q;

endmodule
